// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: sequences each instruction through
// fetch/decode/execute/memory/writeback, drives every datapath strobe,
// flags unsupported encodings and counts retired instructions.
module mips_multicycle_control #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             zero,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic [1:0]       PCSrc,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             ALUSrc,
    output logic             MemToReg,
    output logic [2:0]       ALUOp,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StAddiEx = 4'd10,
        StAddiWb = 4'd11
    } state_e;

    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpJ     = 6'h02;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b100;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rtype_legal;
    logic [2:0]       func_aluop;
    logic             retire;

    // R-type function decode: ALU operation and legality of the func field.
    always_comb begin
        rtype_legal = 1'b1;
        func_aluop  = AluAdd;
        unique case (func)
            6'h20:   func_aluop = AluAdd;
            6'h22:   func_aluop = AluSub;
            6'h24:   func_aluop = AluAnd;
            6'h25:   func_aluop = AluOr;
            6'h2A:   func_aluop = AluSlt;
            default: rtype_legal = 1'b0;
        endcase
    end

    // Next-state and control-strobe decode; reset forces every strobe low.
    always_comb begin
        state_d  = StFetch;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        PCSrc    = 2'b00;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ALUSrc   = 1'b0;
        MemToReg = 1'b0;
        ALUOp    = AluAdd;
        illegal  = 1'b0;
        retire   = 1'b0;
        case (state_q)
            StFetch: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                state_d = StDecode;
            end
            StDecode: begin
                case (opcode)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    OpAddi:     state_d = StAddiEx;
                    OpRType: begin
                        if (rtype_legal) begin
                            state_d = StExec;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default:    illegal = 1'b1;
                endcase
            end
            StMemAdr: begin
                ALUSrc  = 1'b1;
                state_d = (opcode == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                MemRead = 1'b1;
                ALUSrc  = 1'b1;
                state_d = StMemWb;
            end
            StMemWb: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            StMemWr: begin
                MemWrite = 1'b1;
                ALUSrc   = 1'b1;
                retire   = 1'b1;
            end
            StExec: begin
                ALUOp   = func_aluop;
                state_d = StAluWb;
            end
            StAluWb: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                MemToReg = 1'b1;
                ALUOp    = func_aluop;
                retire   = 1'b1;
            end
            StBranch: begin
                ALUOp   = AluSub;
                PCSrc   = 2'b01;
                PCWrite = zero;
                retire  = 1'b1;
            end
            StJump: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
                retire  = 1'b1;
            end
            StAddiEx: begin
                ALUSrc  = 1'b1;
                state_d = StAddiWb;
            end
            StAddiWb: begin
                ALUSrc   = 1'b1;
                RegWrite = 1'b1;
                MemToReg = 1'b1;
                retire   = 1'b1;
            end
            // Unreachable codes 12-15 fall back to fetch with no strobes.
            default: state_d = StFetch;
        endcase
        if (!rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            PCSrc    = 2'b00;
            RegWrite = 1'b0;
            RegDst   = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            ALUSrc   = 1'b0;
            MemToReg = 1'b0;
            ALUOp    = AluAdd;
            illegal  = 1'b0;
            retire   = 1'b0;
        end
    end

    // Retired-instruction counter advances on the edge leaving a final state.
    always_comb begin
        cnt_d = cnt_q;
        if (retire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state       = state_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: each instruction pushes its
// expected per-cycle control vector and count, popped and compared mid-cycle.
module tb_mips_multicycle_control;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [5:0]       opcode;
    logic [5:0]       func;
    logic             zero;
    logic             PCWrite, IRWrite, RegWrite, RegDst, MemRead, MemWrite;
    logic             ALUSrc, MemToReg, illegal;
    logic [1:0]       PCSrc;
    logic [2:0]       ALUOp;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    typedef struct packed {
        logic [17:0]      ctl;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             sb_q[$];
    int               n_checks;
    int               n_errors;
    logic [CNT_W-1:0] exp_cnt;

    mips_multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .func        (func),
        .zero        (zero),
        .PCWrite     (PCWrite),
        .IRWrite     (IRWrite),
        .PCSrc       (PCSrc),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .ALUSrc      (ALUSrc),
        .MemToReg    (MemToReg),
        .ALUOp       (ALUOp),
        .illegal     (illegal),
        .state       (state),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, PCWrite, IRWrite, PCSrc, RegWrite, RegDst, MemRead, MemWrite,
    //  ALUSrc, MemToReg, ALUOp, illegal}
    function automatic logic [17:0] mk(input logic [3:0] st, input logic pcw, input logic irw,
                                       input logic [1:0] pcs, input logic rw, input logic rd,
                                       input logic mr, input logic mw, input logic as,
                                       input logic mtr, input logic [2:0] aop,
                                       input logic ill);
        return {st, pcw, irw, pcs, rw, rd, mr, mw, as, mtr, aop, ill};
    endfunction

    function automatic logic [17:0] observed();
        return {state, PCWrite, IRWrite, PCSrc, RegWrite, RegDst, MemRead, MemWrite,
                ALUSrc, MemToReg, ALUOp, illegal};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input logic [17:0] ctl);
        exp_t e;
        e.ctl = ctl;
        e.cnt = exp_cnt;
        sb_q.push_back(e);
    endtask

    // Pop one expectation per cycle and compare it mid-cycle.
    task automatic drain(input string tag);
        exp_t e;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            e = sb_q.pop_front();
            check({tag, "_ctl"}, 32'(observed()), 32'(e.ctl));
            check({tag, "_cnt"}, 32'(instr_count), 32'(e.cnt));
            @(posedge clk);
            #1;
        end
    endtask

    localparam logic [17:0] CtlFetch  = 18'b0000_1_1_00_0_0_1_0_0_0_000_0;
    localparam logic [17:0] CtlDecode = 18'b0001_0_0_00_0_0_0_0_0_0_000_0;

    // kind: 0 lw, 1 sw, 2 R-type, 3 beq, 4 j, 5 addi, 6 illegal
    task automatic run_instr(input string tag, input int kind, input logic [5:0] op,
                             input logic [5:0] fn, input logic z, input logic [2:0] aop);
        opcode = op;
        func   = fn;
        zero   = z;
        push(CtlFetch);
        if (kind == 6) begin
            push(mk(4'd1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 3'b000, 1));
        end else begin
            push(CtlDecode);
        end
        case (kind)
            0: begin
                push(mk(4'd2, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 3'b000, 0));
                push(mk(4'd3, 0, 0, 2'b00, 0, 0, 1, 0, 1, 0, 3'b000, 0));
                push(mk(4'd4, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 3'b000, 0));
            end
            1: begin
                push(mk(4'd2, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 3'b000, 0));
                push(mk(4'd5, 0, 0, 2'b00, 0, 0, 0, 1, 1, 0, 3'b000, 0));
            end
            2: begin
                push(mk(4'd6, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, aop, 0));
                push(mk(4'd7, 0, 0, 2'b00, 1, 1, 0, 0, 0, 1, aop, 0));
            end
            3: push(mk(4'd8, z, 0, 2'b01, 0, 0, 0, 0, 0, 0, 3'b001, 0));
            4: push(mk(4'd9, 1, 0, 2'b10, 0, 0, 0, 0, 0, 0, 3'b000, 0));
            5: begin
                push(mk(4'd10, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 3'b000, 0));
                push(mk(4'd11, 0, 0, 2'b00, 1, 0, 0, 0, 1, 1, 3'b000, 0));
            end
            default: ;
        endcase
        drain(tag);
        if (kind != 6) exp_cnt = exp_cnt + 1'b1;
    endtask

    initial begin
        exp_t e;
        n_checks = 0;
        n_errors = 0;
        exp_cnt  = '0;
        rst      = 1'b0;
        opcode   = 6'h00;
        func     = 6'h20;
        zero     = 1'b0;
        #3;
        check("reset_ctl", 32'(observed()), 32'(mk(4'd0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0,
                                                     3'b000, 0)));
        check("reset_cnt", 32'(instr_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("release_fetch", 32'(observed()), 32'(CtlFetch));

        run_instr("lw", 0, 6'h23, 6'h00, 1'b0, 3'b000);

        // Abandon a second lw in MEMRD with an asynchronous reset.
        opcode = 6'h23;
        push(CtlFetch);
        push(CtlDecode);
        push(mk(4'd2, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 3'b000, 0));
        drain("lw_abort");
        @(negedge clk);
        check("memrd_state", 32'(state), 32'd3);
        check("memrd_cnt", 32'(instr_count), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_ctl", 32'(observed()), 32'(mk(4'd0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0,
                                                         3'b000, 0)));
        check("async_rst_cnt", 32'(instr_count), 32'd0);
        exp_cnt = '0;
        @(posedge clk);
        #1;
        check("held_rst_state", 32'(state), 32'd0);
        rst = 1'b1;
        #1;
        check("post_rst_fetch", 32'(observed()), 32'(CtlFetch));

        run_instr("sub",     2, 6'h00, 6'h22, 1'b0, 3'b001);
        run_instr("slt",     2, 6'h00, 6'h2A, 1'b0, 3'b100);
        run_instr("or",      2, 6'h00, 6'h25, 1'b0, 3'b011);
        run_instr("beq_t",   3, 6'h04, 6'h00, 1'b1, 3'b000);
        run_instr("beq_nt",  3, 6'h04, 6'h00, 1'b0, 3'b000);
        run_instr("ill_op",  6, 6'h3F, 6'h20, 1'b0, 3'b000);
        run_instr("ill_fn",  6, 6'h00, 6'h01, 1'b0, 3'b000);
        run_instr("addi",    5, 6'h08, 6'h00, 1'b0, 3'b000);
        run_instr("sw",      1, 6'h2B, 6'h00, 1'b0, 3'b000);
        for (int i = 0; i < 16; i++) begin
            run_instr("j", 4, 6'h02, 6'h00, 1'b0, 3'b000);
        end
        @(negedge clk);
        check("final_cnt", 32'(instr_count), 32'(exp_cnt));
        check("final_fetch", 32'(observed()), 32'(CtlFetch));
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
